// File: rtl/i4004_cycle_seq.sv
// Two-phase clock generator and 8-subcycle machine-cycle sequencer for the i4004 core,
// with run/halt/single-step control that gates the CPU at instruction-cycle boundaries.
module i4004_cycle_seq #(
  parameter int PHASE_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic             PHI1_o,
  output logic             PHI2_o,
  output logic             SYNC_o,
  output logic [2:0]       state_o,
  output logic             phi1_stb_o,
  output logic             phi2_stb_o,
  output logic             bus_oe_o,
  output logic             halted_o,
  output logic             cycle_done_o,
  output logic [CNT_W-1:0] icount_o,
  output logic [1:0]       ctrl_state_o
);

  typedef enum logic [1:0] {
    CTRL_HALT = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_STEP = 2'd2
  } ctrl_t;

  localparam int             CW       = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(PHASE_LEN - 1);
  localparam logic [2:0]     ST_A1    = 3'd0;
  localparam logic [2:0]     ST_A3    = 3'd2;
  localparam logic [2:0]     ST_X3    = 3'd7;

  ctrl_t            ctrl_q, ctrl_d;
  logic [1:0]       q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             phi1_stb_q, phi1_stb_d;
  logic             phi2_stb_q, phi2_stb_d;
  logic             at_boundary;
  logic             restart;

  // Reset parks the sequencer exactly on the boundary slot so a restart looks like a normal advance.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q     <= CTRL_HALT;
      q_q        <= 2'd1;
      cnt_q      <= CNT_LAST;
      state_q    <= ST_X3;
      icount_q   <= '0;
      phi1_stb_q <= 1'b0;
      phi2_stb_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      icount_q   <= icount_d;
      phi1_stb_q <= phi1_stb_d;
      phi2_stb_q <= phi2_stb_d;
    end
  end

  assign at_boundary = (state_q == ST_X3) && (q_q == 2'd1) && (cnt_q == CNT_LAST);

  always_comb begin
    ctrl_d     = ctrl_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    icount_d   = icount_q;
    phi1_stb_d = 1'b0;
    phi2_stb_d = 1'b0;
    restart    = 1'b0;

    case (ctrl_q)
      CTRL_HALT: begin
        // run wins over step when both are presented in the same clock
        if (run_i) begin
          ctrl_d  = CTRL_RUN;
          restart = 1'b1;
        end else if (step_i) begin
          ctrl_d  = CTRL_STEP;
          restart = 1'b1;
        end
      end
      default: begin
        if (at_boundary) begin
          icount_d = icount_q + 1'b1;
          if (run_i) begin
            ctrl_d  = CTRL_RUN;
            restart = 1'b1;
          end else begin
            ctrl_d = CTRL_HALT;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          q_d   = q_q + 2'd1;
          if (q_q == 2'd1) begin
            state_d    = state_q + 3'd1;
            phi2_stb_d = 1'b1;
          end
          if (q_q == 2'd3) begin
            phi1_stb_d = 1'b1;
          end
        end
      end
    endcase

    // Leaving the boundary slot always lands on the first PHI2 quarter of A1.
    if (restart) begin
      q_d        = 2'd2;
      cnt_d      = '0;
      state_d    = ST_A1;
      phi2_stb_d = 1'b1;
    end
  end

  assign PHI1_o       = (q_q == 2'd0);
  assign PHI2_o       = (q_q == 2'd2);
  assign SYNC_o       = (state_q != ST_X3);
  assign state_o      = state_q;
  assign phi1_stb_o   = phi1_stb_q;
  assign phi2_stb_o   = phi2_stb_q;
  assign bus_oe_o     = (state_q <= ST_A3);
  assign halted_o     = (ctrl_q == CTRL_HALT);
  assign cycle_done_o = (ctrl_q != CTRL_HALT) && at_boundary;
  assign icount_o     = icount_q;
  assign ctrl_state_o = ctrl_q;

endmodule

// File: tb/tb_i4004_cycle_seq.sv
// Bench for i4004_cycle_seq: timing of phases/strobes, run/halt/step control, async reset,
// and a PHASE_LEN=1 instance for the single-clock-quarter corner.
module tb_i4004_cycle_seq;

  logic        clk = 1'b0;
  logic        rst_n, run, step;
  logic        phi1, phi2, sync, phi1_stb, phi2_stb, bus_oe, halted, cycle_done;
  logic [2:0]  state;
  logic [15:0] icount;
  logic [1:0]  ctrl_state;
  logic        phi1_1, phi2_1, sync_1, phi1_stb_1, phi2_stb_1, bus_oe_1, halted_1, cycle_done_1;
  logic [2:0]  state_1;
  logic [15:0] icount_1;
  logic [1:0]  ctrl_state_1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_icount;

  always #5 clk = ~clk;

  i4004_cycle_seq #(.PHASE_LEN(2), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1), .PHI2_o(phi2), .SYNC_o(sync), .state_o(state),
    .phi1_stb_o(phi1_stb), .phi2_stb_o(phi2_stb), .bus_oe_o(bus_oe),
    .halted_o(halted), .cycle_done_o(cycle_done), .icount_o(icount),
    .ctrl_state_o(ctrl_state)
  );

  i4004_cycle_seq #(.PHASE_LEN(1), .CNT_W(16)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .step_i(step),
    .PHI1_o(phi1_1), .PHI2_o(phi2_1), .SYNC_o(sync_1), .state_o(state_1),
    .phi1_stb_o(phi1_stb_1), .phi2_stb_o(phi2_stb_1), .bus_oe_o(bus_oe_1),
    .halted_o(halted_1), .cycle_done_o(cycle_done_1), .icount_o(icount_1),
    .ctrl_state_o(ctrl_state_1)
  );

  task automatic wait_cd(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cycle_done === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s: cycle_done not seen, got none within 200 clocks, required one", name); end
  endtask

  task automatic wait_state(input string name, input logic [2:0] target);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state === target) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s: state %0d not reached, last %0d", name, target, state); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; step = 1'b0; exp_icount = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({halted, sync, phi1, phi2, bus_oe, phi1_stb, phi2_stb, cycle_done} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b required 10000000",
               {halted, sync, phi1, phi2, bus_oe, phi1_stb, phi2_stb, cycle_done});
    end
    n_tests++;
    if (state !== 3'd7 || icount !== 16'd0) begin
      n_fail++; $display("FAIL reset_state: got state %0d icount %0d required 7 0", state, icount);
    end
  endtask

  task automatic test_startup();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({phi2, phi2_stb, halted, bus_oe, phi1} !== 5'b11010 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL startup: got phi2/stb/halt/oe/phi1 %b state %0d required 11010 state 0",
               {phi2, phi2_stb, halted, bus_oe, phi1}, state);
    end
    repeat (24) @(negedge clk);
    n_tests++;
    if (state !== 3'd3) begin n_fail++; $display("FAIL startup_m1: got state %0d required 3", state); end
  endtask

  task automatic test_free_run();
    int phi1_hi = 0, p1s = 0, p2s = 0, sync_lo = 0, oe_hi = 0, cdn = 0, last_p1 = -1, bad = 0;
    logic [15:0] exp_idx;
    wait_cd("free_run_align");
    exp_icount++;
    exp_q.push_back(16'd63); exp_q.push_back(16'd127); exp_q.push_back(16'd191);
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (phi1) phi1_hi++;
      if (!sync) sync_lo++;
      if (bus_oe) oe_hi++;
      if (phi2_stb) begin p2s++; if (!phi2) bad++; end
      if (phi1_stb) begin
        p1s++;
        if (!phi1) bad++;
        if (last_p1 >= 0) begin
          n_tests++;
          if (i - last_p1 !== 8) begin n_fail++; $display("FAIL phi1_period: got %0d required 8", i - last_p1); end
        end
        last_p1 = i;
      end
      if (cycle_done) begin
        cdn++; exp_icount++;
        exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hffff;
        n_tests++;
        if (16'(i) !== exp_idx) begin n_fail++; $display("FAIL cd_timing: got clock %0d required %0d", i, exp_idx); end
      end
    end
    @(negedge clk);
    n_tests++;
    if (phi1_hi !== 48 || p1s !== 24 || p2s !== 24 || bad !== 0) begin
      n_fail++; $display("FAIL phase_counts: got phi1_hi %0d p1s %0d p2s %0d bad %0d required 48 24 24 0",
                         phi1_hi, p1s, p2s, bad);
    end
    n_tests++;
    if (sync_lo !== 24 || oe_hi !== 72 || cdn !== 3) begin
      n_fail++; $display("FAIL sync_oe_cd: got sync_lo %0d oe %0d cd %0d required 24 72 3", sync_lo, oe_hi, cdn);
    end
    n_tests++;
    if (icount !== exp_icount) begin n_fail++; $display("FAIL free_icount: got %0d required %0d", icount, exp_icount); end
  endtask

  task automatic test_halt();
    int bad = 0;
    wait_state("halt_a2", 3'd1);
    run = 1'b0;
    wait_cd("halt_boundary");
    exp_icount++;
    @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || state !== 3'd7 || phi1 !== 1'b0 || phi2 !== 1'b0 || icount !== exp_icount) begin
      n_fail++; $display("FAIL halt_entry: got halted %b state %0d phi %b%b icount %0d required 1 7 00 %0d",
                         halted, state, phi1, phi2, icount, exp_icount);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!halted || phi1 || phi2 || phi1_stb || phi2_stb || cycle_done || state !== 3'd7 || icount !== exp_icount) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL halt_hold: got %0d bad clocks required 0", bad); end
  endtask

  task automatic test_step();
    int active, cdn, in_step;
    logic [15:0] exp_v;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      step = 1'b1;
      exp_q.push_back(exp_icount + 16'd1);
      exp_icount++;
      active = 0; cdn = 0; in_step = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        step = 1'b0;
        if (!halted) begin
          active++;
          if (cycle_done) cdn++;
          if (ctrl_state === 2'd2) in_step++;
        end else if (active > 0) break;
      end
      exp_v = exp_q.pop_front();
      n_tests++;
      if (active !== 64 || cdn !== 1 || in_step !== 64) begin
        n_fail++; $display("FAIL step_len: got active %0d cd %0d step_clks %0d required 64 1 64", active, cdn, in_step);
      end
      n_tests++;
      if (icount !== exp_v || halted !== 1'b1) begin
        n_fail++; $display("FAIL step_icount: got %0d halted %b required %0d 1", icount, halted, exp_v);
      end
    end
  endtask

  task automatic test_step_while_running();
    int cdn = 0, bad = 0;
    @(negedge clk);
    run = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      step = (i == 10);
      if (halted || ctrl_state !== 2'd1) bad++;
      if (cycle_done) cdn++;
    end
    step = 1'b0;
    exp_icount += 16'd2;
    @(negedge clk);
    n_tests++;
    if (cdn !== 2 || bad !== 0 || icount !== exp_icount) begin
      n_fail++; $display("FAIL step_running: got cd %0d bad %0d icount %0d required 2 0 %0d", cdn, bad, icount, exp_icount);
    end
  endtask

  task automatic test_run_and_step();
    int cdn = 0, bad = 0;
    run = 1'b0;
    wait_cd("rs_halt");
    exp_icount++;
    @(negedge clk);
    run = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n_tests++;
    if (ctrl_state !== 2'd1 || halted !== 1'b0 || phi2_stb !== 1'b1) begin
      n_fail++; $display("FAIL run_step_both: got ctrl %0d halted %b stb %b required 1 0 1", ctrl_state, halted, phi2_stb);
    end
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      if (halted) bad++;
      if (cycle_done) cdn++;
    end
    exp_icount += 16'd2;
    n_tests++;
    if (cdn !== 2 || bad !== 0) begin
      n_fail++; $display("FAIL run_step_nohalt: got cd %0d halted clocks %0d required 2 0", cdn, bad);
    end
  endtask

  task automatic test_async_reset();
    wait_state("rst_m1", 3'd3);
    #2 rst_n = 1'b0;
    #1;
    exp_icount = '0;
    n_tests++;
    if ({halted, sync, phi1, phi2, bus_oe, phi1_stb, phi2_stb, cycle_done} !== 8'b1000_0000 ||
        state !== 3'd7 || icount !== exp_icount) begin
      n_fail++; $display("FAIL async_reset: got %b state %0d icount %0d required 10000000 7 0",
                         {halted, sync, phi1, phi2, bus_oe, phi1_stb, phi2_stb, cycle_done}, state, icount);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (halted !== 1'b1 || state !== 3'd7 || phi2 !== 1'b0 || icount !== 16'd0) begin
      n_fail++; $display("FAIL reset_stay_halted: got halted %b state %0d phi2 %b icount %0d required 1 7 0 0",
                         halted, state, phi2, icount);
    end
  endtask

  task automatic test_phase_len1();
    int cdn = 0, p1 = 0, p1s = 0, sync_lo = 0, bad = 0;
    bit ok = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cycle_done_1 === 1'b1) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL pl1_align: cycle_done not seen within 100 clocks"); end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (phi1_1) p1++;
      if (phi1_stb_1) p1s++;
      if (!sync_1) sync_lo++;
      if (phi1_stb_1 !== phi1_1 || phi2_stb_1 !== phi2_1) bad++;
      if (i == 0 && state_1 !== 3'd0) bad++;
      if (cycle_done_1) begin
        cdn++;
        if (i != 31 && i != 63) bad++;
      end
    end
    n_tests++;
    if (cdn !== 2 || p1 !== 16 || p1s !== 16 || sync_lo !== 8 || bad !== 0) begin
      n_fail++; $display("FAIL pl1_timing: got cd %0d phi1 %0d stb %0d sync_lo %0d bad %0d required 2 16 16 8 0",
                         cdn, p1, p1s, sync_lo, bad);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_free_run();
    test_halt();
    test_step();
    test_step_while_running();
    test_run_and_step();
    test_async_reset();
    test_phase_len1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
